// File: rtl/se_scheduler.sv
// Sound-effect scheduler: latches game-event sound requests, arbitrates them by
// fixed priority with preemption, and sequences each effect's note list from a
// small ROM onto a single square-wave tone generator.
module se_scheduler #(
  parameter int unsigned TICK_DIV = 9000
) (
  input  logic        i_clk,
  input  logic        i_res,
  input  logic        i_req_fixed,
  input  logic        i_req_line,
  input  logic        i_req_reset,
  input  logic        i_mute,
  output logic        o_tone_en,
  output logic [15:0] o_half_period,
  output logic        o_busy,
  output logic [1:0]  o_snd_id,
  output logic        o_note_pls
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);

  typedef enum logic [1:0] {StIdle, StLoad, StPlay} state_e;

  state_e        state_q, state_d;
  logic [2:0]    pend_q, pend_d;
  logic [1:0]    cur_id_q, cur_id_d;
  logic [1:0]    idx_q, idx_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    dur_q, dur_d;
  logic [15:0]   hp_q, hp_d;
  logic [1:0]    snd_q, snd_d;
  logic          pls_q, pls_d;

  logic [2:0]    req_vec, pend_eff;
  logic [1:0]    gid_q, gid_eff;
  logic          preempt, wrap, note_done;
  logic [15:0]   rom_hp;
  logic [7:0]    rom_dur;
  logic          rom_last;

  // Highest set bit of a pending vector; 0 when empty (callers gate on non-empty).
  function automatic logic [1:0] top_id(input logic [2:0] v);
    logic [1:0] id;
    if (v[2]) begin
      id = 2'd2;
    end else if (v[1]) begin
      id = 2'd1;
    end else begin
      id = 2'd0;
    end
    return id;
  endfunction

  // Note ROM: {half_period, dur_ms, last} per (effect id, note index).
  always_comb begin
    rom_hp   = 16'd0;
    rom_dur  = 8'd0;
    rom_last = 1'b1;
    case ({cur_id_q, idx_q})
      4'b00_00: begin rom_hp = 16'd4500; rom_dur = 8'd30;  rom_last = 1'b1; end
      4'b01_00: begin rom_hp = 16'd3000; rom_dur = 8'd40;  rom_last = 1'b0; end
      4'b01_01: begin rom_hp = 16'd2250; rom_dur = 8'd40;  rom_last = 1'b0; end
      4'b01_10: begin rom_hp = 16'd1800; rom_dur = 8'd80;  rom_last = 1'b1; end
      4'b10_00: begin rom_hp = 16'd9000; rom_dur = 8'd100; rom_last = 1'b0; end
      4'b10_01: begin rom_hp = 16'd6000; rom_dur = 8'd100; rom_last = 1'b1; end
      default:  begin rom_hp = 16'd0;    rom_dur = 8'd0;   rom_last = 1'b1; end
    endcase
  end

  // Request merging, arbitration and timing decodes.
  always_comb begin
    req_vec   = {i_req_reset, i_req_line, i_req_fixed};
    // Fresh pulses are visible to the idle grant in the same cycle they arrive.
    pend_eff  = pend_q | req_vec;
    gid_q     = top_id(pend_q);
    gid_eff   = top_id(pend_eff);
    // Preemption only considers already-latched requests.
    preempt   = (pend_q != 3'b000) && (gid_q > cur_id_q);
    wrap      = (presc_q == PRESC_MAX);
    note_done = wrap && (dur_q <= 8'd1);
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_eff;
    cur_id_d = cur_id_q;
    idx_d    = idx_q;
    presc_d  = presc_q;
    dur_d    = dur_q;
    hp_d     = hp_q;
    snd_d    = snd_q;
    pls_d    = 1'b0;

    if (i_mute) begin
      // Mute drops everything, including requests arriving this cycle.
      state_d = StIdle;
      pend_d  = 3'b000;
      idx_d   = 2'd0;
      presc_d = '0;
      dur_d   = 8'd0;
      hp_d    = 16'd0;
      snd_d   = 2'd3;
    end else begin
      case (state_q)
        StIdle: begin
          if (pend_eff != 3'b000) begin
            state_d  = StLoad;
            cur_id_d = gid_eff;
            idx_d    = 2'd0;
            pend_d   = pend_eff & ~(3'b001 << gid_eff);
          end
        end

        StLoad: begin
          presc_d = '0;
          dur_d   = rom_dur;
          if (preempt) begin
            state_d  = StLoad;
            cur_id_d = gid_q;
            idx_d    = 2'd0;
            pend_d   = pend_eff & ~(3'b001 << gid_q);
          end else begin
            state_d = StPlay;
            hp_d    = rom_hp;
            snd_d   = cur_id_q;
            pls_d   = 1'b1;
          end
        end

        StPlay: begin
          if (preempt) begin
            state_d  = StLoad;
            cur_id_d = gid_q;
            idx_d    = 2'd0;
            pend_d   = pend_eff & ~(3'b001 << gid_q);
          end else begin
            presc_d = wrap ? '0 : (presc_q + PRESC_ONE);
            if (wrap) begin
              dur_d = dur_q - 8'd1;
            end
            if (note_done) begin
              if (!rom_last) begin
                state_d = StLoad;
                idx_d   = idx_q + 2'd1;
              end else if (pend_eff != 3'b000) begin
                state_d  = StLoad;
                cur_id_d = gid_eff;
                idx_d    = 2'd0;
                pend_d   = pend_eff & ~(3'b001 << gid_eff);
              end else begin
                state_d = StIdle;
                hp_d    = 16'd0;
                snd_d   = 2'd3;
              end
            end
          end
        end

        default: begin
          state_d = StIdle;
          hp_d    = 16'd0;
          snd_d   = 2'd3;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      state_q  <= StIdle;
      pend_q   <= 3'b000;
      cur_id_q <= 2'd0;
      idx_q    <= 2'd0;
      presc_q  <= '0;
      dur_q    <= 8'd0;
      hp_q     <= 16'd0;
      snd_q    <= 2'd3;
      pls_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      cur_id_q <= cur_id_d;
      idx_q    <= idx_d;
      presc_q  <= presc_d;
      dur_q    <= dur_d;
      hp_q     <= hp_d;
      snd_q    <= snd_d;
      pls_q    <= pls_d;
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    o_tone_en     = (state_q == StPlay);
    o_busy        = (state_q != StIdle);
    o_half_period = hp_q;
    o_snd_id      = snd_q;
    o_note_pls    = pls_q;
  end

endmodule

// File: tb/tb_se_scheduler.sv
// Bench for se_scheduler: table-driven single/simultaneous request vectors plus
// hand-written preemption, merge/mute and reset sequences. Expected notes are
// queued when stimulus is driven and checked as the DUT plays them.
module tb_se_scheduler;

  localparam int unsigned TD = 10;

  logic        clk;
  logic        res;
  logic        rf, rl, rr, mute;
  logic        tone_en;
  logic [15:0] half;
  logic        busy;
  logic [1:0]  snd_id;
  logic        note_pls;

  int cyc;
  int tests;
  int fails;

  typedef struct {
    int id;
    int hp;
    int len;
    int start;
  } note_t;

  note_t exp_q[$];

  typedef struct {
    string           name;
    logic [2:0]      req;      // {reset, line, fixed}
    int              n;
    logic [3:0][1:0]  ids;
    logic [3:0][15:0] hps;
    logic [3:0][15:0] lens;
  } vec_t;

  vec_t vecs[5];

  se_scheduler #(.TICK_DIV(TD)) dut (
    .i_clk         (clk),
    .i_res         (res),
    .i_req_fixed   (rf),
    .i_req_line    (rl),
    .i_req_reset   (rr),
    .i_mute        (mute),
    .o_tone_en     (tone_en),
    .o_half_period (half),
    .o_busy        (busy),
    .o_snd_id      (snd_id),
    .o_note_pls    (note_pls)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_note(input int id, input int hp, input int len, input int start);
    note_t n;
    n.id = id;
    n.hp = hp;
    n.len = len;
    n.start = start;
    exp_q.push_back(n);
  endtask

  // Advance to the negedge of relative cycle r.
  task automatic wait_rel(input int t0, input int r);
    while (cyc - t0 < r) @(negedge clk);
  endtask

  // Note monitor: measures each tone_en run and compares against the queue.
  initial begin : monitor
    bit in_note;
    int run, n_hp, n_id, n_start;
    note_t e;
    in_note = 1'b0;
    run = 0;
    n_hp = 0;
    n_id = 0;
    n_start = 0;
    forever begin
      @(negedge clk);
      if (tone_en) begin
        if (!in_note) begin
          in_note = 1'b1;
          run = 0;
          n_hp = int'(half);
          n_id = int'(snd_id);
          n_start = cyc;
          check("note_pls at note start", int'(note_pls), 1);
        end else if (note_pls) begin
          check("note_pls inside note", int'(note_pls), 0);
        end
        run++;
      end else begin
        if (note_pls) check("note_pls with tone off", int'(note_pls), 0);
        if (in_note) begin
          in_note = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected note start", n_start, -1);
          end else begin
            e = exp_q.pop_front();
            check("note start cycle", n_start, e.start);
            check("note half period", n_hp, e.hp);
            check("note snd_id", n_id, e.id);
            check("note length", run, e.len);
          end
        end
      end
    end
  end

  task automatic check_idle(input string tag);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " tone_en"}, int'(tone_en), 0);
    check({tag, " snd_id"}, int'(snd_id), 3);
    check({tag, " half_period"}, int'(half), 0);
    check({tag, " note_pls"}, int'(note_pls), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int t0, st, idle_at;
    @(negedge clk);
    t0 = cyc;
    {rr, rl, rf} = v.req;
    st = 2;
    for (int i = 0; i < v.n; i++) begin
      push_note(int'(v.ids[i]), int'(v.hps[i]), int'(v.lens[i]), t0 + st);
      st += int'(v.lens[i]) + 1;
    end
    idle_at = st - 1;
    @(negedge clk);
    {rr, rl, rf} = 3'b000;
    check({v.name, " LOAD busy"}, int'(busy), 1);
    check({v.name, " LOAD tone_en"}, int'(tone_en), 0);
    check({v.name, " LOAD snd_id"}, int'(snd_id), 3);
    wait_rel(t0, idle_at - 1);
    check({v.name, " busy before idle"}, int'(busy), 1);
    @(negedge clk);
    check_idle(v.name);
    @(negedge clk);
    check({v.name, " notes outstanding"}, exp_q.size(), 0);
  endtask

  initial begin : main
    int t0;
    tests = 0;
    fails = 0;
    res = 1'b1;
    {rr, rl, rf} = 3'b000;
    mute = 1'b0;

    vecs[0] = '{name: "fixed", req: 3'b001, n: 1,
                ids: {2'd0, 2'd0, 2'd0, 2'd0},
                hps: {16'd0, 16'd0, 16'd0, 16'd4500},
                lens: {16'd0, 16'd0, 16'd0, 16'd300}};
    vecs[1] = '{name: "line", req: 3'b010, n: 3,
                ids: {2'd0, 2'd1, 2'd1, 2'd1},
                hps: {16'd0, 16'd1800, 16'd2250, 16'd3000},
                lens: {16'd0, 16'd800, 16'd400, 16'd400}};
    vecs[2] = '{name: "reset", req: 3'b100, n: 2,
                ids: {2'd0, 2'd0, 2'd2, 2'd2},
                hps: {16'd0, 16'd0, 16'd6000, 16'd9000},
                lens: {16'd0, 16'd0, 16'd1000, 16'd1000}};
    vecs[3] = '{name: "reset+fixed", req: 3'b101, n: 3,
                ids: {2'd0, 2'd0, 2'd2, 2'd2},
                hps: {16'd0, 16'd4500, 16'd6000, 16'd9000},
                lens: {16'd0, 16'd300, 16'd1000, 16'd1000}};
    vecs[4] = '{name: "line+fixed", req: 3'b011, n: 4,
                ids: {2'd0, 2'd1, 2'd1, 2'd1},
                hps: {16'd4500, 16'd1800, 16'd2250, 16'd3000},
                lens: {16'd300, 16'd800, 16'd400, 16'd400}};

    repeat (3) @(negedge clk);
    check_idle("reset state");
    res = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("idle after reset");

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Line preempts a playing fixed effect; fixed is dropped.
    @(negedge clk);
    t0 = cyc;
    rf = 1'b1;
    push_note(0, 4500, 50, t0 + 2);
    @(negedge clk);
    rf = 1'b0;
    wait_rel(t0, 50);
    rl = 1'b1;
    push_note(1, 3000, 400, t0 + 53);
    push_note(1, 2250, 400, t0 + 454);
    push_note(1, 1800, 800, t0 + 855);
    @(negedge clk);
    rl = 1'b0;
    wait_rel(t0, 52);
    check("preempt LOAD tone_en", int'(tone_en), 0);
    check("preempt LOAD busy", int'(busy), 1);
    check("preempt LOAD holds snd_id", int'(snd_id), 0);
    check("preempt LOAD holds half", int'(half), 4500);
    wait_rel(t0, 53);
    check("preempt new snd_id", int'(snd_id), 1);
    check("preempt new half", int'(half), 3000);
    wait_rel(t0, 1655);
    check_idle("after preempt");
    @(negedge clk);
    check("preempt notes outstanding", exp_q.size(), 0);

    // Repeated line requests merge into one replay; mute aborts it.
    @(negedge clk);
    t0 = cyc;
    rl = 1'b1;
    push_note(1, 3000, 400, t0 + 2);
    push_note(1, 2250, 400, t0 + 403);
    push_note(1, 1800, 800, t0 + 804);
    push_note(1, 3000, 96, t0 + 1605);
    @(negedge clk);
    rl = 1'b0;
    wait_rel(t0, 100);
    rl = 1'b1;
    @(negedge clk);
    rl = 1'b0;
    wait_rel(t0, 200);
    rl = 1'b1;
    @(negedge clk);
    rl = 1'b0;
    wait_rel(t0, 1604);
    check("replay LOAD tone_en", int'(tone_en), 0);
    check("replay LOAD busy", int'(busy), 1);
    wait_rel(t0, 1700);
    mute = 1'b1;
    @(negedge clk);
    check("mute tone_en", int'(tone_en), 0);
    check("mute busy", int'(busy), 0);
    wait_rel(t0, 1705);
    {rr, rl, rf} = 3'b111;
    @(negedge clk);
    {rr, rl, rf} = 3'b000;
    wait_rel(t0, 1710);
    mute = 1'b0;
    wait_rel(t0, 1800);
    check_idle("after mute");
    check("mute notes outstanding", exp_q.size(), 0);

    // Reset mid-note with a line replay pending.
    @(negedge clk);
    t0 = cyc;
    rl = 1'b1;
    push_note(1, 3000, 149, t0 + 2);
    @(negedge clk);
    rl = 1'b0;
    wait_rel(t0, 100);
    rl = 1'b1;
    @(negedge clk);
    rl = 1'b0;
    wait_rel(t0, 150);
    res = 1'b1;
    @(negedge clk);
    check_idle("mid-note reset");
    res = 1'b0;
    wait_rel(t0, 400);
    check_idle("after reset release");
    check("reset notes outstanding", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/se_scheduler.md
# se_scheduler

Sound-effect scheduler between the game core's event pulses and the single square-wave tone generator. It latches one-cycle sound requests: block fixed, line removed, game reset. It arbitrates them by fixed priority, with preemption, onto the shared generator. For each granted effect it sequences a short note list from an internal ROM, driving half-period and enable for each note with millisecond-accurate durations.

## Interface
- TICK_DIV, 9000: clock cycles per duration unit (1 ms at 9 MHz); benches use 10.
- i_clk  in  1  system clock (9 MHz domain).
- i_res  in  1  synchronous reset, active-high.
- i_req_fixed  in  1  block-fixed request pulse (id 0, lowest priority).
- i_req_line  in  1  line-removed request pulse (id 1).
- i_req_reset  in  1  game-reset request pulse (id 2, highest priority).
- i_mute  in  1  level; while high, requests are ignored and playback is aborted.
- o_tone_en  out  1  generator enable.
- o_half_period  out  16  generator half period in i_clk cycles.
- o_busy  out  1  high whenever state is not IDLE.
- o_snd_id  out  2  id of the effect now sequenced; 3 = none.
- o_note_pls  out  1  one-cycle pulse on the first enabled cycle of each note.

## Operation
- Pending register, 3 bits, one per id.
  - A request pulse with i_mute=0 sets its bit at the clock edge.
  - Repeat requests while a bit is already set merge into that bit, so at most one play per id is queued.
  - A bit clears when its id is granted.
- Note ROM, {half_period, dur_ms}, with an end-of-list flag on the last entry:
  - id 0: {4500, 30}.
  - id 1: {3000, 40}, {2250, 40}, {1800, 80}.
  - id 2: {9000, 100}, {6000, 100}.
- States: IDLE, LOAD, PLAY.
- IDLE → LOAD when any pending bit is set.
  - Grant the highest pending id, set note index to 0, and clear that pending bit.
- LOAD, exactly 1 cycle:
  - Register the ROM entry and clear the prescaler.
  - Load the duration counter with dur_ms.
  - Go to PLAY.
- PLAY:
  - The prescaler counts 0..TICK_DIV-1; each wrap decrements the duration counter.
  - When the counter reaches 0 on a wrap:
    - If the note is not the last, increment the index and go to LOAD.
    - If it is the last and any pending bit is set, grant the highest and go to LOAD.
    - Otherwise go to IDLE.
- Preemption: in LOAD or PLAY, a pending bit with id greater than o_snd_id wins.
  - Next cycle enters LOAD with that id at index 0.
  - The preempted effect is dropped, not resumed.
- Equal- or lower-priority requests during playback only stay pending; they never preempt.
- i_mute=1:
  - Clear all pending bits and go to IDLE next edge.
  - Requests arriving while muted are lost.
- Priority among simultaneous pending bits: 2 > 1 > 0.

## Timing
- Reset value of every output:
  - o_tone_en=0, o_half_period=0, o_busy=0, o_snd_id=3, o_note_pls=0.
  - Pending bits, index and counters are 0.
- Request latency: pulse in cycle N sets pending at edge N; the grant and LOAD happen in cycle N+1.
  - o_tone_en=1 and o_note_pls=1 are first seen in cycle N+2.
- o_tone_en is 1 only in PLAY, for exactly dur_ms*TICK_DIV cycles per note.
  - Each LOAD cycle between notes or effects gives one cycle of o_tone_en=0.
- o_half_period and o_snd_id are updated at the LOAD→PLAY edge.
  - They hold their values through the LOAD gap.
  - On the transition to IDLE, o_half_period clears to 0 and o_snd_id returns to 3.
- o_busy is 1 from the cycle after the grant edge until the return to IDLE.
- Reset mid-note: all outputs return to reset values on the next edge, and no queued effect survives.
- Counter widths: prescaler is $clog2(TICK_DIV) bits; duration counter is 8 bits (dur_ms ≤ 255).

## Test plan
- TICK_DIV=10, i_req_fixed pulse at cycle 0.
  - o_note_pls at cycle 2; o_half_period=4500, o_tone_en=1 for cycles 2..301.
  - o_busy=0 and o_snd_id=3 from cycle 302.
- i_req_line pulse:
  - Three note pulses: 400 cycles at 3000, 400 at 2250, then 800 at 1800.
  - Exactly one o_tone_en=0 cycle between notes.
- i_req_fixed at cycle 0, i_req_line at cycle 50.
  - Fixed aborts: o_tone_en=0 at cycle 52 (LOAD), line note 1 starts at cycle 53.
  - The fixed effect never replays.
- i_req_fixed and i_req_reset in the same cycle.
  - id 2 plays 1000 cycles at 9000, then 1000 at 6000.
  - Then id 0 plays 300 cycles at 4500, then idle.
- Mid-line playback:
  - A repeated i_req_line (twice) queues exactly one replay.
  - Asserting i_mute during the replay drives o_tone_en=0 and o_busy=0 next edge; further requests under mute are ignored.
- i_res during PLAY with id 1 pending:
  - All outputs reach reset values next edge; no playback follows after release.
